// File: rtl/alu_cdb_buffer_if.sv
// Handshake bundle between the ALU result port, the buffer and the CDB arbiter.
// The buffer takes the slave view; the producer/arbiter side takes the master view.
interface alu_cdb_buffer_if #(
   parameter int TAG_W = 6
);
   logic             in_valid;
   logic [63:0]      in_result;
   logic [TAG_W-1:0] in_tag;
   logic             in_ready;
   logic             out_ready;
   logic             out_valid;
   logic [63:0]      out_result;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_result, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_result, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );
endinterface

// File: rtl/alu_cdb_buffer.sv
// In-order circular FIFO holding completed ALU results until the CDB grants the bus.
// One cycle enqueue-to-head latency; flush squashes everything; reset is synchronous.
module alu_cdb_buffer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   alu_cdb_buffer_if.slave        bus,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   typedef struct packed {
      logic [63:0]      result;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [AW:0]     count_q, count_d;
   entry_t          hold_q, hold_d;
   logic            enq, deq;

   // Handshakes are decided from registered occupancy only, so a full buffer
   // cannot accept in the same cycle it drains.
   always_comb begin
      enq     = bus.in_valid && (count_q != FULL_COUNT);
      deq     = bus.out_ready && (count_q != '0);
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      hold_d  = hold_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + 1'b1;
         if (deq) begin
            head_d = head_q + 1'b1;
            hold_d = mem_q[head_q];
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: entry storage and the output hold register are deliberately not
   // reset; out_valid masks them until a real entry is written.
   always_ff @(posedge clock) begin
      hold_q <= hold_d;
      if (enq) mem_q[tail_q] <= '{result: bus.in_result, tag: bus.in_tag};
   end

   // When empty, the last broadcast entry stays on the bus instead of stale storage.
   assign bus.out_valid  = (count_q != '0);
   assign bus.in_ready   = (count_q != FULL_COUNT);
   assign bus.out_result = bus.out_valid ? mem_q[head_q].result : hold_q.result;
   assign bus.out_tag    = bus.out_valid ? mem_q[head_q].tag    : hold_q.tag;
   assign count          = count_q;
endmodule

// File: tb/tb_alu_cdb_buffer.sv
// Self-checking bench for alu_cdb_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model of the FIFO.
module tb_alu_cdb_buffer;
   localparam int DEPTH = 4;
   localparam int TAG_W = 6;

   logic       clock = 1'b0;
   logic       reset;
   logic       flush;
   logic [2:0] count;

   alu_cdb_buffer_if #(.TAG_W(TAG_W)) bus ();

   alu_cdb_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus.slave),
      .count (count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0]      result;
      logic [TAG_W-1:0] tag;
   } item_t;

   item_t model_q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit rst_n, input bit fl, input bit iv,
                        input logic [63:0] res, input logic [TAG_W-1:0] tg, input bit ordy);
      reset         = rst_n;
      flush         = fl;
      bus.in_valid  = iv;
      bus.in_result = res;
      bus.in_tag    = tg;
      bus.out_ready = ordy;
   endtask

   // Advance the model by the inputs currently driven, clock the DUT, then
   // compare every observable output on the falling edge.
   task automatic step(input string name);
      bit    enq;
      bit    deq;
      item_t it;
      if (!reset || flush) begin
         model_q.delete();
      end else begin
         enq = bus.in_valid && (model_q.size() < DEPTH);
         deq = bus.out_ready && (model_q.size() > 0);
         if (deq) void'(model_q.pop_front());
         if (enq) begin
            it.result = bus.in_result;
            it.tag    = bus.in_tag;
            model_q.push_back(it);
         end
      end
      @(posedge clock);
      @(negedge clock);
      check({name, "_count"}, 64'(count), 64'(model_q.size()));
      check({name, "_out_valid"}, 64'(bus.out_valid), 64'(model_q.size() != 0));
      check({name, "_in_ready"}, 64'(bus.in_ready), 64'(model_q.size() != DEPTH));
      if (model_q.size() != 0) begin
         check({name, "_out_result"}, bus.out_result, model_q[0].result);
         check({name, "_out_tag"}, 64'(bus.out_tag), 64'(model_q[0].tag));
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clock);

      // Reset state
      drive(1'b0, 1'b1, 1'b1, 64'h1, 6'd1, 1'b1);
      step("reset");
      check("reset_in_ready_const", 64'(bus.in_ready), 64'd1);

      // Single enqueue appears one cycle later
      drive(1'b1, 1'b0, 1'b1, 64'h5, 6'd3, 1'b0);
      step("single");
      check("single_result_const", bus.out_result, 64'h5);
      check("single_tag_const", 64'(bus.out_tag), 64'd3);
      check("single_count_const", 64'(count), 64'd1);

      // Fill past capacity: fifth tag dropped, then drain in order
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      step("fill_reset");
      for (int t = 1; t <= 5; t++) begin
         drive(1'b1, 1'b0, 1'b1, 64'(t * 100), 6'(t), 1'b0);
         step("fill");
      end
      check("fill_count_const", 64'(count), 64'd4);
      check("fill_in_ready_const", 64'(bus.in_ready), 64'd0);
      for (int t = 1; t <= 4; t++) begin
         check("drain_tag_const", 64'(bus.out_tag), 64'(t));
         drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
         step("drain");
      end
      check("drain_count_const", 64'(count), 64'd0);

      // Full with simultaneous offer and grant: dequeue only
      for (int t = 1; t <= 4; t++) begin
         drive(1'b1, 1'b0, 1'b1, 64'(t), 6'(t + 8), 1'b0);
         step("refill");
      end
      drive(1'b1, 1'b0, 1'b1, 64'hbad, 6'd63, 1'b1);
      step("full_both");
      check("full_both_count_const", 64'(count), 64'd3);

      // Steady state at count 2 with pointer wrap
      drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
      step("flush_pre");
      for (int t = 10; t < 12; t++) begin
         drive(1'b1, 1'b0, 1'b1, 64'(t) << 32, 6'(t), 1'b0);
         step("pre2");
      end
      for (int t = 12; t < 22; t++) begin
         drive(1'b1, 1'b0, 1'b1, 64'(t) << 32, 6'(t), 1'b1);
         step("steady");
         check("steady_count_const", 64'(count), 64'd2);
         check("steady_head_tag_const", 64'(bus.out_tag), 64'(t - 1));
      end

      // Flush at count 3 overrides simultaneous enqueue and dequeue
      drive(1'b1, 1'b0, 1'b1, 64'h77, 6'd22, 1'b0);
      step("to3");
      check("to3_count_const", 64'(count), 64'd3);
      drive(1'b1, 1'b1, 1'b1, 64'h88, 6'd23, 1'b1);
      step("flush3");
      check("flush3_count_const", 64'(count), 64'd0);
      check("flush3_valid_const", 64'(bus.out_valid), 64'd0);

      // Mid-operation reset, then first enqueue lands at head
      for (int t = 0; t < 2; t++) begin
         drive(1'b1, 1'b0, 1'b1, 64'(t + 40), 6'(t + 40), 1'b0);
         step("pre_rst");
      end
      drive(1'b0, 1'b0, 1'b1, 64'h99, 6'd5, 1'b1);
      step("mid_reset");
      check("mid_reset_count_const", 64'(count), 64'd0);
      drive(1'b1, 1'b0, 1'b1, 64'hdeadbeefbaadbeef, 6'd7, 1'b0);
      step("post_reset");
      check("post_reset_result_const", bus.out_result, 64'hdeadbeefbaadbeef);
      check("post_reset_tag_const", 64'(bus.out_tag), 64'd7);

      // Random traffic with phases biased toward filling and draining
      for (int i = 0; i < 800; i++) begin
         int bias;
         bias = (i / 100) % 3;
         drive($urandom_range(99) != 0,
               $urandom_range(39) == 0,
               $urandom_range(3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2)),
               {$urandom, $urandom},
               6'($urandom),
               $urandom_range(3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2)));
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/alu_cdb_buffer.md
ALU_CDB_BUFFER -- requirements
Module: alu_cdb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the entry count; legal values 2, 4, 8, 16 only.
REQ-002 Parameter TAG_W, default 6, SHALL set the destination physical-register tag width.
REQ-003 Port clock, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: SHALL be synchronous, active-low reset; 0 on a rising edge of clock resets the block.
REQ-005 Port flush, input, 1: SHALL discard all queued entries (mispredict squash).
REQ-006 Port in_valid, input, 1: SHALL indicate the ALU presents a completed result this cycle.
REQ-007 Port in_result, input, 64: SHALL carry the 64-bit ALU result.
REQ-008 Port in_tag, input, TAG_W: SHALL carry the destination tag of that result.
REQ-009 Port in_ready, output, 1: SHALL indicate an entry is free, so issue may send the ALU an instruction.
REQ-010 Port out_ready, input, 1: SHALL indicate the CDB grants this buffer the bus this cycle.
REQ-011 Port out_valid, output, 1: SHALL indicate out_result/out_tag hold a valid head entry.
REQ-012 Port out_result, output, 64: SHALL carry the head entry result.
REQ-013 Port out_tag, output, TAG_W: SHALL carry the head entry tag.
REQ-014 Port count, output, log2(DEPTH)+1: SHALL report the number of occupied entries.

Function
REQ-015 Buffer SHALL be an in-order circular FIFO with head and tail pointers of log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-016 Enqueue SHALL occur exactly when in_valid=1 and in_ready=1 at a rising edge; in_valid while in_ready=0 SHALL be ignored (input dropped, no state change).
REQ-017 Dequeue SHALL occur exactly when out_valid=1 and out_ready=1 at a rising edge.
REQ-018 in_ready SHALL equal (count != DEPTH), from registered state only; no same-cycle accept on a dequeue while full.
REQ-019 out_valid SHALL equal (count != 0); out_result/out_tag SHALL be the head entry when out_valid=1 and SHALL hold previous values (not required zero) when out_valid=0.
REQ-020 Latency SHALL be exactly 1 cycle: an entry enqueued at edge N SHALL be visible on out_* after edge N when buffer was empty; no combinational in->out bypass.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-022 count SHALL increment by 1 on enqueue-only, decrement by 1 on dequeue-only, never exceed DEPTH nor underflow below 0.
REQ-023 out_valid=1 SHALL be held with out_result/out_tag stable until dequeued (CDB stall).
REQ-024 flush=1 at an edge SHALL set count=0, head=tail=0, and override any same-cycle enqueue or dequeue.
REQ-025 Entries SHALL be broadcast in enqueue order with result and tag never mismatched.

Reset
REQ-026 reset=0 at an edge SHALL set count=0, head=tail=0, out_valid=0, in_ready=1, overriding flush, enqueue and dequeue.
REQ-027 Entry storage SHALL NOT require reset; out_result/out_tag after reset are don't-care while out_valid=0.
REQ-028 Reset asserted mid-operation SHALL discard all entries; first post-reset enqueue SHALL appear at head.

Verification
REQ-029 Reset, then enqueue {64'h5, tag 3} with out_ready=0 -> next cycle out_valid=1, out_result=5, out_tag=3, count=1.
REQ-030 DEPTH=4, out_ready=0, enqueue tags 1..5 on five consecutive cycles -> count=4, in_ready=0 after fourth, tag 5 dropped; then out_ready=1 -> tags 1,2,3,4 in order, count reaches 0.
REQ-031 Full buffer, in_valid=1 and out_ready=1 same cycle -> dequeue only, count 4->3, input not accepted.
REQ-032 count=2, in_valid=1 and out_ready=1 for 10 cycles with rising tags -> count stays 2, pointers wrap, output order equals input order.
REQ-033 count=3, flush=1 with in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-034 count=2, reset=0 with flush=0, in_valid=1 -> next cycle count=0; enqueue 64'hdeadbeefbaadbeef tag 7 -> visible at head next cycle.
